// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: default widths, FSM states and
// the latched request record.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } req_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after
// last_grant+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic w_found;

    // Outer loop walks priority distance 1..NUM_REQ; inner loop finds the
    // requester sitting at that distance from the last grant.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j] &&
                    (j == ((int'(i_last_grant) + k) % NUM_REQ))) begin
                    w_found   = 1'b1;
                    o_pick[j] = 1'b1;
                    o_idx     = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between NUM_REQ
// masters; each access is a one-cycle strobe followed by an idle gap.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data_in,
    input  logic [DATA_W-1:0]          mem_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0] r_sel;
    req_rec_t           r_rec;
    logic [DATA_W-1:0]  r_rdata;
    logic [NUM_REQ-1:0] r_rvalid;

    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    req_rec_t           w_rec;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick),
        .o_idx        (w_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_rec       = '0;
        w_rec.we    = req_we[w_idx];
        w_rec.addr  = req_addr[w_idx*ADDR_W +: ADDR_W];
        w_rec.wdata = req_wdata[w_idx*DATA_W +: DATA_W];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = ACC;
            ACC:     w_state_next = r_rec.we ? IDLE : RD_WAIT;
            RD_WAIT: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_sel        <= '0;
            r_rec        <= '0;
            r_rdata      <= '0;
            r_rvalid     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= '0;
            if (r_state == IDLE && w_any) begin
                r_last_grant <= w_idx;
                r_sel        <= w_pick;
                r_rec        <= w_rec;
            end
            // Memory data is valid during RD_WAIT; capture it as that state ends.
            if (r_state == RD_WAIT) begin
                r_rdata  <= mem_data_out;
                r_rvalid <= r_sel;
            end
        end
    end

    assign gnt         = (r_state == ACC) ? r_sel : '0;
    assign mem_write   = (r_state == ACC) &&  r_rec.we;
    assign mem_read    = (r_state == ACC) && !r_rec.we;
    assign mem_addr    = r_rec.addr;
    assign mem_data_in = r_rec.wdata;
    assign busy        = (r_state != IDLE);
    assign rvalid      = r_rvalid;
    assign rdata       = r_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 32x8 synchronous memory port (read/write strobes, 5-bit addr, 8-bit data in/out) between NUM_REQ requesters.
- Uses round-robin arbitration.
- Sequences each access as a strobe pulse followed by an idle gap, and returns read data with a per-requester valid pulse.
- Sits between test/DMA-style masters and the memory block's mem-side signals.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 5, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester access request; held until gnt.
- req_we  input  NUM_REQ  1=write, 0=read; stable while req high.
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  flattened write data; same slicing.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse in the cycle the access is issued.
- rvalid  output  NUM_REQ  one-hot, one-cycle pulse when rdata holds that requester's read result.
- rdata  output  DATA_W  read data, shared by all requesters, qualified by rvalid.
- busy  output  1  high whenever FSM is not IDLE.
- mem_read  output  1  read strobe to memory.
- mem_write  output  1  write strobe to memory.
- mem_addr  output  ADDR_W  address to memory.
- mem_data_in  output  DATA_W  write data to memory.
- mem_data_out  input  DATA_W  read data from memory; valid the cycle after mem_read.

Behaviour:
- Reset:
  - All outputs are 0 the cycle after rst is sampled high: gnt, rvalid, rdata, busy, mem_read, mem_write, mem_addr, mem_data_in.
  - FSM goes to IDLE; last_grant = NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, ACC, RD_WAIT. All outputs are registered or decoded from state registers only.
- IDLE:
  - If any req bit is high, the round-robin picker selects the first requester at or after last_grant+1, wrapping modulo NUM_REQ.
  - Its we/addr/wdata and index are latched; last_grant is updated; next state is ACC.
  - With no req bits high, FSM stays in IDLE.
- ACC (exactly 1 cycle):
  - gnt[idx]=1; mem_addr/mem_data_in are driven from the latch.
  - mem_write=1 if we, else mem_read=1.
  - Next state: write -> IDLE; read -> RD_WAIT.
- RD_WAIT (1 cycle):
  - Both strobes are 0; mem_data_out is sampled into rdata at the end of the cycle.
  - rvalid[idx] pulses the following cycle (FSM back in IDLE); next state is IDLE.
- Strobes are never high in consecutive cycles. mem_read and mem_write are never high together.
- Latency, with req sampled in cycle 0:
  - gnt and strobe in cycle 1.
  - Write done; the next request can be sampled in cycle 2.
  - Read: rvalid in cycle 3.
- Throughput: writes 1 per 2 cycles; reads 1 per 3 cycles. The IDLE cycle that shows rvalid can also sample a new request.
- mem_addr/mem_data_in hold their last values outside ACC. Only the strobes qualify them.
- rdata holds its value until the next read completes.
- A req dropped before gnt is allowed: if it is dropped while in IDLE, that requester is not picked. Once latched, the access completes even if req drops.
- Simultaneous requests: exactly one gnt per access. Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.
- Reset mid-operation (ACC or RD_WAIT): the access is abandoned, no rvalid is produced, strobes are 0 the next cycle, and last_grant is reinitialised.
- Address/data are passed unmodified; no width conversion. The full range 0..2^ADDR_W-1 is legal.

Decomposition:
- Package mem_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The arb_state_t enum {IDLE, ACC, RD_WAIT}.
  - A request record typedef {we, addr, wdata} used for the latch.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Combinational.
  - Inputs: req vector and last_grant index.
  - Outputs: one-hot pick, index, any_req.
  - Instantiated once by mem_arbiter.

Test Plan:
- Reset: hold rst 2 cycles with req=2'b11 -> all outputs 0, no gnt; after release, req0 wins first.
- Single write: req0 we=1 addr=5'h03 wdata=8'hA5 -> in cycle 1, gnt=2'b01, mem_write=1, mem_addr=03, mem_data_in=A5; cycle 2 strobes 0.
- Read-back on behavioural memory: req1 read addr=5'h03 -> cycle 1 gnt=2'b10, mem_read=1; cycle 3 rvalid=2'b10, rdata=8'hA5.
- Contention: both requesters held high, alternating reads/writes, 8 accesses -> grant sequence 0,1,0,1,0,1,0,1; never two strobes in adjacent cycles.
- Boundary: write addr=5'h1F data=8'hFF, then write addr=5'h00 data=8'h00, read both back -> rdata FF then 00; no aliasing.
- Reset during RD_WAIT: req0 read, assert rst in cycle 2 -> no rvalid at cycle 3, busy=0, and the next request goes to req0.
